hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_div_timer.sv | 24 ++
 rtl/hazard_unit.sv | 107 ++++++++++
 tb/tb_hazard_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

  // Width of an architectural register index
  localparam int REG_W = 5;

  // Default number of stall cycles for a multi-cycle divide
  localparam int DIV_LATENCY_DEF = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_div_timer.sv
// Loadable down-counter used to time a divide stall; done flags a zero count.
module hazard_div_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count;

  // Load wins over decrement; the count never goes below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (load)               count <= loadVal;
    else if (dec && count != '0) count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, taken-branch flush and, with
// HAZARD_DIV_EN defined, a multi-cycle divide stall (DIV_WAIT state).
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_MemRead,
  input  logic [REG_W-1:0] id_ex_RegisterRd,
  input  logic [REG_W-1:0] if_id_RegisterRs1,
  input  logic [REG_W-1:0] if_id_RegisterRs2,
  input  logic             if_id_UsesRs1,
  input  logic             if_id_UsesRs2,
  input  logic             ex_BranchTaken,
  input  logic             ex_DivStart,
  output logic             pcWrite,
  output logic             if_id_Write,
  output logic             if_id_Flush,
  output logic             id_ex_Bubble,
  output logic             id_ex_Write,
  output logic             ex_mem_Bubble,
  output logic             divBusy,
  output logic [31:0]      stallCount
);

  state_t state, nextState;
  logic   loadUse;

  // x0 is never a real dependency; only sources the instruction reads count
  assign loadUse = id_ex_MemRead && (id_ex_RegisterRd != '0) &&
                   ((if_id_UsesRs1 && (if_id_RegisterRs1 == id_ex_RegisterRd)) ||
                    (if_id_UsesRs2 && (if_id_RegisterRs2 == id_ex_RegisterRd)));

`ifdef HAZARD_DIV_EN
  localparam logic [7:0] LOAD_VAL = 8'(DIV_LATENCY - 1);
  logic timerDone;

  hazard_div_timer #(.W(8)) uTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    ((state == IDLE) && ex_DivStart),
    .loadVal (LOAD_VAL),
    .dec     (state == DIV_WAIT),
    .done    (timerDone)
  );
`else
  logic unusedDiv;
  assign unusedDiv = ex_DivStart;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next state and stall/flush controls; reset holds the IDLE defaults
  always_comb begin
    nextState     = state;
    pcWrite       = 1'b1;
    if_id_Write   = 1'b1;
    if_id_Flush   = 1'b0;
    id_ex_Bubble  = 1'b0;
    id_ex_Write   = 1'b1;
    ex_mem_Bubble = 1'b0;
    divBusy       = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          // Branch squashes the dependent instruction, so no stall is needed
          if (ex_BranchTaken) begin
            if_id_Flush  = 1'b1;
            id_ex_Bubble = 1'b1;
          end else if (loadUse) begin
            pcWrite      = 1'b0;
            if_id_Write  = 1'b0;
            id_ex_Bubble = 1'b1;
          end
`ifdef HAZARD_DIV_EN
          if (ex_DivStart) nextState = DIV_WAIT;
`endif
        end
`ifdef HAZARD_DIV_EN
        DIV_WAIT: begin
          // EX is frozen: branch, divide start and load-use are ignored
          pcWrite       = 1'b0;
          if_id_Write   = 1'b0;
          id_ex_Write   = 1'b0;
          ex_mem_Bubble = 1'b1;
          divBusy       = 1'b1;
          if (timerDone) nextState = IDLE;
        end
`endif
        default: nextState = IDLE;
      endcase
    end
  end

  // Free-running count of stalled cycles, wraps modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        stallCount <= '0;
    else if (!pcWrite) stallCount <= stallCount + 32'd1;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver pushes the expected outputs
// for each cycle, the monitor pops and compares on the falling edge.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memRead = 1'b0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic        u1 = 1'b0, u2 = 1'b0, br = 1'b0, dv = 1'b0;
  logic        pcWrite, ifIdWrite, ifIdFlush, idExBubble, idExWrite, exMemBubble, divBusy;
  logic [31:0] stallCount;

  // {pcWrite, if_id_Write, if_id_Flush, id_ex_Bubble, id_ex_Write, ex_mem_Bubble, divBusy}
  localparam logic [6:0] O_IDLE = 7'b1100100;
  localparam logic [6:0] O_LU   = 7'b0001100;
  localparam logic [6:0] O_BR   = 7'b1111100;
  localparam logic [6:0] O_DIV  = 7'b0000011;

  typedef struct {
    string       name;
    logic [6:0]  outs;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] expCnt = 0;

  always #5 clk = ~clk;

  hazard_unit #(.DIV_LATENCY(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_ex_MemRead     (memRead),
    .id_ex_RegisterRd  (rd),
    .if_id_RegisterRs1 (rs1),
    .if_id_RegisterRs2 (rs2),
    .if_id_UsesRs1     (u1),
    .if_id_UsesRs2     (u2),
    .ex_BranchTaken    (br),
    .ex_DivStart       (dv),
    .pcWrite           (pcWrite),
    .if_id_Write       (ifIdWrite),
    .if_id_Flush       (ifIdFlush),
    .id_ex_Bubble      (idExBubble),
    .id_ex_Write       (idExWrite),
    .ex_mem_Bubble     (exMemBubble),
    .divBusy           (divBusy),
    .stallCount        (stallCount)
  );

  // Apply one cycle of stimulus just after the rising edge and queue its expectation
  task automatic step(input string nm, input logic rst, input logic mr,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic a1, input logic a2, input logic b, input logic v,
                      input logic [6:0] o);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; memRead = mr; rd = d; rs1 = s1; rs2 = s2;
    u1 = a1; u2 = a2; br = b; dv = v;
    if (!rst) expCnt = 0;
    e.name = nm; e.outs = o; e.cnt = expCnt;
    q.push_back(e);
    if (!o[6]) expCnt = expCnt + 1;
  endtask

  task automatic idle(input string nm);
    step(nm, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
  endtask

  // Monitor: outputs are valid every cycle, compare mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks = checks + 2;
      if ({pcWrite, ifIdWrite, ifIdFlush, idExBubble, idExWrite, exMemBubble, divBusy} != e.outs) begin
        failures = failures + 1;
        $display("FAIL %s outs got=%b want=%b", e.name,
                 {pcWrite, ifIdWrite, ifIdFlush, idExBubble, idExWrite, exMemBubble, divBusy}, e.outs);
      end
      if (stallCount != e.cnt) begin
        failures = failures + 1;
        $display("FAIL %s stallCount got=%0d want=%0d", e.name, stallCount, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a load-use pattern present: no hazard may show
    step("reset_hold", 0, 1, 5, 5, 0, 1, 0, 0, 0, O_IDLE);
    idle("after_reset");
    step("load_use_rs1", 1, 1, 5, 5, 0, 1, 0, 0, 0, O_LU);
    idle("after_load_use");
    step("rd_zero", 1, 1, 0, 0, 0, 1, 0, 0, 0, O_IDLE);
    step("rs2_unused", 1, 1, 5, 3, 5, 1, 0, 0, 0, O_IDLE);
    step("load_use_rs2", 1, 1, 5, 3, 5, 1, 1, 0, 0, O_LU);
    step("no_memread", 1, 0, 5, 5, 0, 1, 0, 0, 0, O_IDLE);
    step("branch_beats_lu", 1, 1, 5, 5, 0, 1, 0, 1, 0, O_BR);
    step("branch_only", 1, 0, 0, 0, 0, 0, 0, 1, 0, O_BR);
`ifdef HAZARD_DIV_EN
    step("div_start", 1, 0, 0, 0, 0, 0, 0, 0, 1, O_IDLE);
    for (int i = 0; i < 8; i++) begin
      // inputs during the wait are ignored
      if (i == 3) step("div_wait_ignored", 1, 1, 5, 5, 0, 1, 0, 1, 1, O_DIV);
      else        step("div_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, O_DIV);
    end
    idle("div_done");
    step("branch_and_div", 1, 0, 0, 0, 0, 0, 0, 1, 1, O_BR);
    for (int i = 0; i < 8; i++) step("div_wait_b", 1, 0, 0, 0, 0, 0, 0, 0, 0, O_DIV);
    idle("div_done_b");
    step("div_start_c", 1, 0, 0, 0, 0, 0, 0, 0, 1, O_IDLE);
    step("div_wait_c", 1, 0, 0, 0, 0, 0, 0, 0, 0, O_DIV);
    step("div_wait_c", 1, 0, 0, 0, 0, 0, 0, 0, 0, O_DIV);
    step("reset_in_div", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE);
    step("div_after_reset", 1, 0, 0, 0, 0, 0, 0, 0, 1, O_IDLE);
    for (int i = 0; i < 8; i++) step("div_wait_d", 1, 0, 0, 0, 0, 0, 0, 0, 0, O_DIV);
    idle("div_done_d");
`else
    step("div_ignored", 1, 0, 0, 0, 0, 0, 0, 0, 1, O_IDLE);
    idle("div_ignored_next");
    idle("div_ignored_next2");
`endif
    @(posedge clk);
    @(negedge clk);
    #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL queue_drain left=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
